// File: rtl/counter_sequencer.sv
// Run controller for an 8-bit programmable counter: loads a start value, paces
// ENABLE through a prescaler, and reports terminal-count / done pulses.
module counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_term,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_reload,
  input  logic               stop,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_value,
  output logic               cnt_enable,
  output logic               busy,
  output logic               tc,
  output logic               done,
  output logic [7:0]         reload_count,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               reload_q, reload_d;
  logic [PRESC_W-1:0] prescaler_q, prescaler_d;
  logic [7:0]         reload_count_q, reload_count_d;
  logic               presc_hit;
  logic               at_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      start_q        <= '0;
      term_q         <= '0;
      presc_q        <= '0;
      reload_q       <= 1'b0;
      prescaler_q    <= '0;
      reload_count_q <= '0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      term_q         <= term_d;
      presc_q        <= presc_d;
      reload_q       <= reload_d;
      prescaler_q    <= prescaler_d;
      reload_count_q <= reload_count_d;
    end
  end

  assign presc_hit    = (prescaler_q == presc_q);
  assign at_term      = (cnt_value == term_q);
  assign reload_count = reload_count_q;
  assign dbg_state    = state_q;

  // Config handshake: a transfer happens on a rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is high only in IDLE, so offers made
  // while a run is in progress are simply not taken.
  always_comb begin
    state_d        = state_q;
    start_d        = start_q;
    term_d         = term_q;
    presc_d        = presc_q;
    reload_d       = reload_q;
    prescaler_d    = prescaler_q;
    reload_count_d = reload_count_q;
    cfg_ready      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_enable     = 1'b0;
    tc             = 1'b0;
    done           = 1'b0;
    busy           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          start_d        = cfg_start;
          term_d         = cfg_term;
          presc_d        = cfg_presc;
          reload_d       = cfg_reload;
          reload_count_d = '0;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          cnt_load       = 1'b1;
          cnt_load_value = start_q;
          prescaler_d    = '0;
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        // stop has priority over the terminal check in the same cycle
        if (stop) begin
          state_d = S_DONE;
        end else if (at_term) begin
          tc = 1'b1;
          if (reload_q) begin
            state_d = S_LOAD;
            if (reload_count_q != 8'hFF) reload_count_d = reload_count_q + 8'd1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_enable  = presc_hit;
          prescaler_d = presc_hit ? '0 : prescaler_q + PRESC_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
